// File: rtl/fetch_pkg.sv
// Shared fetch-side definitions: packet width derivation, bundle widths and the
// packet field layout so Decode can slice the same bits the fetch stage packed.
package fetch_pkg;

    localparam int SIZE_INSTRUCTION = 64;
    localparam int SIZE_PC          = 32;
    localparam int SIZE_CTI_LOG     = 4;

    localparam int PKT_W   = SIZE_INSTRUCTION + 2 * SIZE_PC + SIZE_CTI_LOG + 1;
    localparam int FETCH_W = 4;
    localparam int DISP_W  = 4;

    // Packet is {instruction, pc, targetAddr, ctiqTag, prediction}, prediction at bit 0.
    localparam int PRED_LSB   = 0;
    localparam int CTIQ_LSB   = PRED_LSB + 1;
    localparam int TARGET_LSB = CTIQ_LSB + SIZE_CTI_LOG;
    localparam int PC_LSB     = TARGET_LSB + SIZE_PC;
    localparam int INSTR_LSB  = PC_LSB + SIZE_PC;

    typedef struct packed {
        logic [SIZE_INSTRUCTION-1:0] instruction;
        logic [SIZE_PC-1:0]          pc;
        logic [SIZE_PC-1:0]          targetAddr;
        logic [SIZE_CTI_LOG-1:0]     ctiqTag;
        logic                        prediction;
    } fetchPkt_t;

    function automatic logic [SIZE_PC-1:0] pktPc(input logic [PKT_W-1:0] pkt);
        return pkt[PC_LSB +: SIZE_PC];
    endfunction

endpackage

// File: rtl/fetch_compact.sv
// Slot compaction helper: number of valid slots and, for each slot, how many
// valid slots precede it (its write offset from the buffer tail).
module fetch_compact
    import fetch_pkg::*;
#(
    parameter int WIDTH = FETCH_W,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]       valid,
    output logic [CNT_W-1:0]       popCount,
    output logic [WIDTH*CNT_W-1:0] slotOffset
);

    logic [CNT_W-1:0] runSum;

    always_comb begin
        runSum     = '0;
        slotOffset = '0;
        for (int i = 0; i < WIDTH; i++) begin
            slotOffset[i*CNT_W +: CNT_W] = runSum;
            runSum = runSum + CNT_W'(valid[i]);
        end
        popCount = runSum;
    end

endmodule

// File: rtl/inst_buffer_fs2.sv
// Instruction buffer between FetchStage2 and Decode: compacts valid fetch slots
// into a circular FIFO and offers up to DISP_W in-order packets per cycle.
module inst_buffer_fs2 #(
    parameter int PKT_W   = fetch_pkg::PKT_W,
    parameter int DEPTH   = 16,
    parameter int FETCH_W = fetch_pkg::FETCH_W,
    parameter int DISP_W  = fetch_pkg::DISP_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fs2Ready_i,
    input  logic                       inst0Valid_i,
    input  logic                       inst1Valid_i,
    input  logic                       inst2Valid_i,
    input  logic                       inst3Valid_i,
    input  logic [PKT_W-1:0]           inst0Packet_i,
    input  logic [PKT_W-1:0]           inst1Packet_i,
    input  logic [PKT_W-1:0]           inst2Packet_i,
    input  logic [PKT_W-1:0]           inst3Packet_i,
    input  logic                       flush_i,
    input  logic                       decodeReady_i,
    output logic                       out0Valid_o,
    output logic                       out1Valid_o,
    output logic                       out2Valid_o,
    output logic                       out3Valid_o,
    output logic [PKT_W-1:0]           out0Packet_o,
    output logic [PKT_W-1:0]           out1Packet_o,
    output logic [PKT_W-1:0]           out2Packet_o,
    output logic [PKT_W-1:0]           out3Packet_o,
    output logic                       stall_o,
    output logic [$clog2(DEPTH):0]     occupancy_o
);
    import fetch_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int OFF_W = $clog2(FETCH_W + 1);

    logic [IDX_W-1:0]         head;
    logic [IDX_W-1:0]         tail;
    logic [CNT_W-1:0]         count;
    logic [PKT_W-1:0]         mem [DEPTH];

    logic [FETCH_W-1:0]       instValid;
    logic [PKT_W-1:0]         instPacket [FETCH_W];
    logic [OFF_W-1:0]         popCount;
    logic [FETCH_W*OFF_W-1:0] slotOffset;
    logic [IDX_W-1:0]         wrIdx [FETCH_W];
    logic                     wrEn;
    logic [CNT_W-1:0]         wrCnt;
    logic [CNT_W-1:0]         rdCnt;

    logic [DISP_W-1:0]        outValid;
    logic [PKT_W-1:0]         outPacket [DISP_W];

    assign instValid     = {inst3Valid_i, inst2Valid_i, inst1Valid_i, inst0Valid_i};
    assign instPacket[0] = inst0Packet_i;
    assign instPacket[1] = inst1Packet_i;
    assign instPacket[2] = inst2Packet_i;
    assign instPacket[3] = inst3Packet_i;

    fetch_compact #(
        .WIDTH (FETCH_W),
        .CNT_W (OFF_W)
    ) u_compact (
        .valid      (instValid),
        .popCount   (popCount),
        .slotOffset (slotOffset)
    );

    // Stall from the registered count only, so a full 4-wide bundle always fits.
    assign stall_o     = count > CNT_W'(DEPTH - FETCH_W);
    assign occupancy_o = count;
    assign wrEn        = fs2Ready_i & ~stall_o & ~flush_i;
    assign wrCnt       = wrEn ? CNT_W'(popCount) : '0;

    always_comb begin
        rdCnt = '0;
        if (decodeReady_i && !flush_i) begin
            rdCnt = (count < CNT_W'(DISP_W)) ? count : CNT_W'(DISP_W);
        end
    end

    generate
        for (genvar gi = 0; gi < FETCH_W; gi++) begin : g_wrIdx
            assign wrIdx[gi] = tail + IDX_W'(slotOffset[gi*OFF_W +: OFF_W]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_W; i++) begin
            if (wrEn && instValid[i]) begin
                mem[wrIdx[i]] <= instPacket[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + IDX_W'(rdCnt);
            tail  <= tail + IDX_W'(wrCnt);
            count <= count + wrCnt - rdCnt;
        end
    end

    // No bypass: outputs come straight from storage at the current head.
    generate
        for (genvar gi = 0; gi < DISP_W; gi++) begin : g_read
            assign outValid[gi]  = count > CNT_W'(gi);
            assign outPacket[gi] = mem[head + IDX_W'(gi)];
        end
    endgenerate

    assign out0Valid_o  = outValid[0];
    assign out1Valid_o  = outValid[1];
    assign out2Valid_o  = outValid[2];
    assign out3Valid_o  = outValid[3];
    assign out0Packet_o = outPacket[0];
    assign out1Packet_o = outPacket[1];
    assign out2Packet_o = outPacket[2];
    assign out3Packet_o = outPacket[3];

    countBound: assert property (@(posedge clk) disable iff (reset) count <= CNT_W'(DEPTH));

endmodule
